// File: rtl/sram_ctrl_fsm_if.sv
// ============================================================================
// sram_ctrl_fsm_if : client-side command, write-data and read-data channels
// Rev 1.0
// ============================================================================
`default_nettype none

interface sram_ctrl_fsm_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 9
);
  logic [ADDR_WIDTH+3:0] offer;
  logic                  offer_valid;
  logic                  offer_ready;
  logic [DATA_WIDTH-1:0] receive;
  logic                  dfcq_valid;
  logic                  dfcq_ready;
  logic [DATA_WIDTH-1:0] send;
  logic                  send_valid;
  logic                  send_ready;
  logic [1:0]            current_state;
  logic                  error;
  logic                  err_clear;

  modport slave (
    input  offer, offer_valid, receive, dfcq_valid, send_ready, err_clear,
    output offer_ready, dfcq_ready, send, send_valid, current_state, error
  );

  modport master (
    output offer, offer_valid, receive, dfcq_valid, send_ready, err_clear,
    input  offer_ready, dfcq_ready, send, send_valid, current_state, error
  );
endinterface

`default_nettype wire

// File: rtl/sram_ctrl_fsm.sv
// ============================================================================
// sram_ctrl_fsm : SRAM subsystem command FSM with one spare redundancy row
// Rev 1.0
// ============================================================================
`default_nettype none

module sram_ctrl_fsm #(
  parameter int          DATA_WIDTH = 16,
  parameter int          ADDR_WIDTH = 9,
  parameter int          DEPTH      = 512,
  parameter logic [15:0] ERR_DATA   = 16'h000D
) (
  input  wire               CLK,
  input  wire               ASYNCRESETN,
  sram_ctrl_fsm_if.slave    bus
);

  localparam logic [1:0] MEM_OFF   = 2'd0;
  localparam logic [1:0] MEM_ON    = 2'd1;
  localparam logic [1:0] MEM_READ  = 2'd2;
  localparam logic [1:0] MEM_WRITE = 2'd3;

  localparam logic [3:0] CMD_NOP    = 4'd0;
  localparam logic [3:0] CMD_POFF   = 4'd1;
  localparam logic [3:0] CMD_PON    = 4'd2;
  localparam logic [3:0] CMD_READ   = 4'd3;
  localparam logic [3:0] CMD_WRITE  = 4'd4;
  localparam logic [3:0] CMD_REPAIR = 4'd5;

  localparam int                    IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [DATA_WIDTH-1:0] ERR_WORD = DATA_WIDTH'(ERR_DATA);

  logic [1:0]            state, state_nx;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] spare;
  logic [DATA_WIDTH-1:0] send_q;
  logic                  error_q;
  logic                  repair_valid;
  logic [ADDR_WIDTH-1:0] repair_addr;
  logic [ADDR_WIDTH-1:0] wr_addr;

  logic [3:0]            cmd;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  accept;
  logic                  wr_fire;
  logic                  rd_in_range, wr_in_range;
  logic                  rd_spare, wr_spare;
  logic                  err_set;

  assign cmd         = bus.offer[ADDR_WIDTH+3:ADDR_WIDTH];
  assign addr        = bus.offer[ADDR_WIDTH-1:0];
  assign accept      = bus.offer_valid && bus.offer_ready;
  assign wr_fire     = (state == MEM_WRITE) && bus.dfcq_valid;
  assign rd_in_range = {1'b0, addr} < DEPTH_W;
  assign wr_in_range = {1'b0, wr_addr} < DEPTH_W;
  assign rd_spare    = repair_valid && (addr == repair_addr);
  assign wr_spare    = repair_valid && (wr_addr == repair_addr);

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state <= MEM_OFF;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      MEM_OFF: begin
        if (accept && cmd == CMD_PON) state_nx = MEM_ON;
      end
      MEM_ON: begin
        if (accept) begin
          case (cmd)
            CMD_POFF:  state_nx = MEM_OFF;
            CMD_READ:  state_nx = MEM_READ;
            CMD_WRITE: state_nx = MEM_WRITE;
            default:   state_nx = MEM_ON;
          endcase
        end
      end
      MEM_READ: begin
        if (bus.send_ready) state_nx = MEM_ON;
      end
      default: begin
        if (bus.dfcq_valid) state_nx = MEM_ON;
      end
    endcase
  end

  always_comb begin
    bus.offer_ready   = (state == MEM_OFF) || (state == MEM_ON);
    bus.dfcq_ready    = (state == MEM_WRITE);
    bus.send_valid    = (state == MEM_READ);
    bus.current_state = state;
    bus.send          = send_q;
    bus.error         = error_q;
  end

  always_comb begin
    err_set = 1'b0;
    if (accept && state == MEM_OFF) begin
      err_set = (cmd != CMD_NOP) && (cmd != CMD_POFF) && (cmd != CMD_PON);
    end else if (accept && state == MEM_ON) begin
      if (cmd > CMD_REPAIR) err_set = 1'b1;
      else if ((cmd == CMD_READ || cmd == CMD_REPAIR) && !rd_in_range) err_set = 1'b1;
    end else if (wr_fire && !wr_in_range) begin
      err_set = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      send_q       <= '0;
      error_q      <= 1'b0;
      repair_valid <= 1'b0;
      repair_addr  <= '0;
      wr_addr      <= '0;
    end else begin
      if (err_set)            error_q <= 1'b1;
      else if (bus.err_clear) error_q <= 1'b0;

      if (accept && state == MEM_ON) begin
        case (cmd)
          CMD_READ: begin
            if (!rd_in_range) send_q <= ERR_WORD;
            else if (rd_spare) send_q <= spare;
            else               send_q <= mem[addr[IDX_W-1:0]];
          end
          CMD_WRITE: wr_addr <= addr;
          CMD_REPAIR: begin
            if (rd_in_range) begin
              repair_addr  <= addr;
              repair_valid <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Storage is deliberately not reset; state leaving MEM_WRITE on reset blocks any pending write.
  always_ff @(posedge CLK) begin
    if (wr_fire && wr_in_range) begin
      if (wr_spare) spare <= bus.receive;
      else          mem[wr_addr[IDX_W-1:0]] <= bus.receive;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sram_ctrl_fsm.sv
// ============================================================================
// tb_sram_ctrl_fsm : directed self-checking bench for sram_ctrl_fsm (DEPTH=500)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sram_ctrl_fsm;
  logic CLK = 1'b0;
  logic ASYNCRESETN = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 CLK = ~CLK;

  sram_ctrl_fsm_if #(.DATA_WIDTH(16), .ADDR_WIDTH(9)) bus ();

  sram_ctrl_fsm #(
    .DATA_WIDTH(16), .ADDR_WIDTH(9), .DEPTH(500), .ERR_DATA(16'h000D)
  ) dut (
    .CLK(CLK),
    .ASYNCRESETN(ASYNCRESETN),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic cmd(input logic [3:0] c, input logic [8:0] a);
    bus.offer       = {c, a};
    bus.offer_valid = 1'b1;
    step();
    bus.offer_valid = 1'b0;
  endtask

  task automatic wr(input logic [8:0] a, input logic [15:0] d);
    cmd(4'd4, a);
    chk("wr_state", 32'(bus.current_state), 32'd3);
    bus.receive    = d;
    bus.dfcq_valid = 1'b1;
    step();
    bus.dfcq_valid = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [8:0] a, input logic [15:0] exp);
    cmd(4'd3, a);
    chk({tag, "_valid"}, 32'(bus.send_valid), 32'd1);
    chk({tag, "_data"}, 32'(bus.send), 32'(exp));
    bus.send_ready = 1'b1;
    step();
    bus.send_ready = 1'b0;
    chk({tag, "_done"}, 32'(bus.current_state), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.offer = '0; bus.offer_valid = 0; bus.receive = '0; bus.dfcq_valid = 0;
    bus.send_ready = 0; bus.err_clear = 0;
    step(); step();
    chk("rst_state", 32'(bus.current_state), 32'd0);
    chk("rst_error", 32'(bus.error), 32'd0);
    chk("rst_send", 32'(bus.send), 32'd0);
    chk("rst_svalid", 32'(bus.send_valid), 32'd0);
    chk("rst_oready", 32'(bus.offer_ready), 32'd1);
    chk("rst_dready", 32'(bus.dfcq_ready), 32'd0);
    ASYNCRESETN = 1'b1;
    step();

    // 1: READ while powered off is consumed but flags an error
    cmd(4'd3, 9'd5);
    chk("off_read_state", 32'(bus.current_state), 32'd0);
    chk("off_read_err", 32'(bus.error), 32'd1);
    bus.err_clear = 1'b1; step(); bus.err_clear = 1'b0;
    chk("err_clear", 32'(bus.error), 32'd0);

    // 2: basic write then read
    cmd(4'd2, 9'd0);
    chk("pon_state", 32'(bus.current_state), 32'd1);
    wr(9'd5, 16'hBEEF);
    chk("wr_done", 32'(bus.current_state), 32'd1);
    rd("rd5", 9'd5, 16'hBEEF);
    chk("send_hold", 32'(bus.send), 32'hBEEF);
    chk("svalid_low", 32'(bus.send_valid), 32'd0);

    // 3: backpressure; an offered POWER_OFF must be ignored
    cmd(4'd3, 9'd5);
    bus.offer = {4'd1, 9'd0};
    bus.offer_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_valid", 32'(bus.send_valid), 32'd1);
      chk("bp_data", 32'(bus.send), 32'hBEEF);
      chk("bp_oready", 32'(bus.offer_ready), 32'd0);
      step();
    end
    bus.offer_valid = 1'b0;
    bus.send_ready = 1'b1; step(); bus.send_ready = 1'b0;
    chk("bp_done", 32'(bus.current_state), 32'd1);

    // 4: repair redirects addr 7 to the spare row
    wr(9'd7, 16'h1111);
    cmd(4'd5, 9'd7);
    chk("rep_state", 32'(bus.current_state), 32'd1);
    wr(9'd7, 16'h2222);
    rd("rd7_spare", 9'd7, 16'h2222);
    cmd(4'd5, 9'd8);
    rd("rd7_orig", 9'd7, 16'h1111);
    rd("rd8_spare", 9'd8, 16'h2222);

    // 5: out-of-range accesses and last valid row
    cmd(4'd3, 9'd510);
    chk("oor_rd_err", 32'(bus.error), 32'd1);
    chk("oor_rd_data", 32'(bus.send), 32'h000D);
    bus.send_ready = 1'b1; step(); bus.send_ready = 1'b0;
    bus.err_clear = 1'b1; step(); bus.err_clear = 1'b0;
    chk("oor_clr", 32'(bus.error), 32'd0);
    wr(9'd510, 16'h5555);
    chk("oor_wr_state", 32'(bus.current_state), 32'd1);
    chk("oor_wr_err", 32'(bus.error), 32'd1);
    bus.err_clear = 1'b1; step(); bus.err_clear = 1'b0;
    rd("rd5_intact", 9'd5, 16'hBEEF);
    wr(9'd499, 16'hABCD);
    rd("rd499", 9'd499, 16'hABCD);
    chk("edge_noerr", 32'(bus.error), 32'd0);
    bus.err_clear = 1'b1;
    cmd(4'd5, 9'd500);
    bus.err_clear = 1'b0;
    chk("set_beats_clr", 32'(bus.error), 32'd1);
    bus.err_clear = 1'b1; step(); bus.err_clear = 1'b0;
    cmd(4'd9, 9'd0);
    chk("illegal_err", 32'(bus.error), 32'd1);
    chk("illegal_state", 32'(bus.current_state), 32'd1);
    bus.err_clear = 1'b1; step(); bus.err_clear = 1'b0;
    cmd(4'd1, 9'd0);
    cmd(4'd2, 9'd0);
    rd("rd7_persist", 9'd7, 16'h1111);

    // 6: asynchronous reset in the middle of a write
    cmd(4'd4, 9'd5);
    bus.receive = 16'hDEAD;
    #3;
    ASYNCRESETN = 1'b0;
    #1;
    chk("arst_state", 32'(bus.current_state), 32'd0);
    chk("arst_dready", 32'(bus.dfcq_ready), 32'd0);
    bus.dfcq_valid = 1'b1;
    step();
    bus.dfcq_valid = 1'b0;
    ASYNCRESETN = 1'b1;
    step();
    cmd(4'd2, 9'd0);
    rd("rd5_after_rst", 9'd5, 16'hBEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

`default_nettype wire
